dmem_responder: RTL

//  Data-side bus responder for the single-cycle core: services addr/mask/write_enable/read_enable accesses.

---
 rtl/dmem_responder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-side bus responder: byte-maskable RAM plus MMIO UART TX FIFO/serializer.
// Optional 64-bit cycle counter at MMIO 0x8/0xC under `define CYCLE_COUNTER_EN.
module dmem_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter int          BAUD_DIV   = 434,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  mask,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] rdata,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic          mmio_sel;
  logic [3:0]    off;
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign mmio_sel    = addr[31:16] == MMIO_BASE[31:16];
  assign off         = addr[3:0];
  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr;

  logic [31:0] mem [RAM_WORDS];

  // A write is dropped if reset is low at the edge.
  always_ff @(posedge clk) begin
    if (reset && write_enable && !mmio_sel) begin
      for (int n = 0; n < 4; n++) begin
        if (mask[n]) mem[idx][8*n +: 8] <= wdata[8*n +: 8];
      end
    end
  end

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, push_req, push, pop, ovf_clr;

  assign full     = cnt_q == CW'(FIFO_DEPTH);
  assign empty    = cnt_q == '0;
  assign push_req = write_enable & mmio_sel & (off == 4'h0) & mask[0];
  assign push     = push_req & ~full;
  assign ovf_clr  = write_enable & mmio_sel & (off == 4'h4) & mask[0];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (push_req && full) ovf_d = 1'b1;
  end

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy;

  assign busy = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          state_d = START;
          baud_d  = BAUD_LAST;
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          bit_d   = 3'd0;
          baud_d  = BAUD_LAST;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LAST;
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_q == '0) state_d = IDLE;
        else baud_d = baud_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the next state so the pin register tracks the FSM.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign uart_tx = tx_q;

  logic [31:0] status;
  logic [31:0] rd_word;
  logic [31:0] rdata_q, rdata_d;

  assign status = {28'b0, ovf_q, busy, empty, full};

`ifdef CYCLE_COUNTER_EN
  logic [63:0] cyc_q, cyc_d;
  logic [31:0] shadow_q, shadow_d;

  assign cyc_d = cyc_q + 64'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else cyc_q <= cyc_d;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (read_enable && mmio_sel && off == 4'h8) shadow_d = cyc_q[63:32];
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) shadow_q <= '0;
    else shadow_q <= shadow_d;
  end
`endif

  always_comb begin
    rd_word = mem[idx];
    if (mmio_sel) begin
      unique case (off)
        4'h4:    rd_word = status;
`ifdef CYCLE_COUNTER_EN
        4'h8:    rd_word = cyc_q[31:0];
        4'hC:    rd_word = shadow_q;
`endif
        default: rd_word = '0;
      endcase
    end
    rdata_d = read_enable ? rd_word : rdata_q;
  end

  // Falling-edge capture hands the word to the core before its next rise.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule
